gpio_in_debounce: RTL and testbench



---
 rtl/gpio_in_debounce.sv | 97 +++++++++
 tb/tb_gpio_in_debounce.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce
//
// Conditions raw GPIO pad inputs before they reach the APB GPIO peripheral.
// Each pad goes through a two-flop synchroniser and then a per-pin
// debounce/glitch filter. The filter accepts a new level only after the
// synchronised input has disagreed with the current output on enough
// consecutive prescaler ticks.
//
// Ports:
//   HCLK           in   system clock; all logic on the rising edge
//   HRESET         in   synchronous, active-high reset
//   gpio_pad_in    in   [NUM_GPIO]    raw asynchronous pad levels
//   cfg_enable     in   [NUM_GPIO]    per-pin filter enable (0 = sync only)
//   cfg_prescale   in   [PRESC_WIDTH] tick period minus one, in HCLK cycles
//   cfg_threshold  in   [CNT_WIDTH]   mismatching ticks needed to accept (0 acts as 1)
//   gpio_filt_out  out  [NUM_GPIO]    filtered, registered pin levels
//   change_pulse   out  [NUM_GPIO]    one-cycle pulse aligned with each output change
//   tick_o         out  1             registered copy of the prescaler tick
module gpio_in_debounce #(
    parameter int unsigned NUM_GPIO    = 32,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned PRESC_WIDTH = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_GPIO-1:0]    gpio_pad_in,
    input  logic [NUM_GPIO-1:0]    cfg_enable,
    input  logic [PRESC_WIDTH-1:0] cfg_prescale,
    input  logic [CNT_WIDTH-1:0]   cfg_threshold,
    output logic [NUM_GPIO-1:0]    gpio_filt_out,
    output logic [NUM_GPIO-1:0]    change_pulse,
    output logic                   tick_o
);

    localparam logic [PRESC_WIDTH-1:0] PRESC_ONE = 1;
    localparam logic [CNT_WIDTH:0]     CNT_ONE   = 1;

    logic [NUM_GPIO-1:0]    sync0;
    logic [NUM_GPIO-1:0]    sync1;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic                   tick;
    logic [CNT_WIDTH:0]     thr;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_GPIO];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_GPIO];
    logic [NUM_GPIO-1:0]    out_d;

    // ">=" rather than "==" so lowering cfg_prescale below the running count
    // ticks on the next edge instead of wrapping through the full range.
    assign tick = (presc_cnt >= cfg_prescale);

    // Threshold of 0 behaves as 1; one extra bit keeps cnt+1 from overflowing
    // when the threshold is changed mid-count.
    assign thr = (cfg_threshold == '0) ? CNT_ONE : {1'b0, cfg_threshold};

    always_comb begin
        for (int i = 0; i < NUM_GPIO; i++) begin
            out_d[i] = gpio_filt_out[i];
            cnt_d[i] = '0;
            if (!cfg_enable[i]) begin
                out_d[i] = sync1[i];
            end else if (sync1[i] != gpio_filt_out[i]) begin
                if (!tick) begin
                    cnt_d[i] = cnt_q[i];
                end else if (({1'b0, cnt_q[i]} + CNT_ONE) >= thr) begin
                    out_d[i] = sync1[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE[CNT_WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync0         <= '0;
            sync1         <= '0;
            presc_cnt     <= '0;
            gpio_filt_out <= '0;
            change_pulse  <= '0;
            tick_o        <= 1'b0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync0         <= gpio_pad_in;
            sync1         <= sync0;
            presc_cnt     <= tick ? '0 : presc_cnt + PRESC_ONE;
            gpio_filt_out <= out_d;
            change_pulse  <= out_d ^ gpio_filt_out;
            tick_o        <= tick;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_gpio_in_debounce.sv
module tb_gpio_in_debounce;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] gpio_pad_in;
    logic [31:0] cfg_enable;
    logic [15:0] cfg_prescale;
    logic [3:0]  cfg_threshold;
    logic [31:0] gpio_filt_out;
    logic [31:0] change_pulse;
    logic        tick_o;

    int n_checks = 0;
    int n_fail   = 0;

    gpio_in_debounce #(
        .NUM_GPIO   (32),
        .CNT_WIDTH  (4),
        .PRESC_WIDTH(16)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .gpio_pad_in  (gpio_pad_in),
        .cfg_enable   (cfg_enable),
        .cfg_prescale (cfg_prescale),
        .cfg_threshold(cfg_threshold),
        .gpio_filt_out(gpio_filt_out),
        .change_pulse (change_pulse),
        .tick_o       (tick_o)
    );

    always #5 HCLK = ~HCLK;

    // One rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Clean restart: pads low through one reset edge. Returns just after the edge,
    // so stimulus applied next lands before edge 1.
    task automatic do_reset();
        HRESET      = 1'b1;
        gpio_pad_in = '0;
        step();
        HRESET      = 1'b0;
    endtask

    initial begin
        HRESET        = 1'b1;
        gpio_pad_in   = '0;
        cfg_enable    = '0;
        cfg_prescale  = '0;
        cfg_threshold = '0;
        step();
        step();
        check("rst_out", gpio_filt_out, 32'h0);
        check("rst_pulse", change_pulse, 32'h0);
        check("rst_tick", {31'b0, tick_o}, 32'h0);

        // Bypass: pad to output in 3 edges.
        HRESET         = 1'b0;
        gpio_pad_in[0] = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("byp_out_e%0d", e), gpio_filt_out, (e >= 3) ? 32'h1 : 32'h0);
            check($sformatf("byp_pulse_e%0d", e), change_pulse, (e == 3) ? 32'h1 : 32'h0);
            if (e == 1) check("byp_tick", {31'b0, tick_o}, 32'h1);
        end

        // Debounce every cycle, threshold 4: rise at edge 6, then fall at edge 6.
        do_reset();
        cfg_enable     = '1;
        cfg_prescale   = 16'd0;
        cfg_threshold  = 4'd4;
        gpio_pad_in[5] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("rise_out_e%0d", e), gpio_filt_out, (e >= 6) ? 32'h20 : 32'h0);
            check($sformatf("rise_pulse_e%0d", e), change_pulse, (e == 6) ? 32'h20 : 32'h0);
        end
        gpio_pad_in[5] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check($sformatf("fall_out_e%0d", e), gpio_filt_out, (e >= 6) ? 32'h0 : 32'h20);
            check($sformatf("fall_pulse_e%0d", e), change_pulse, (e == 6) ? 32'h20 : 32'h0);
        end

        // Glitch of 2 cycles is rejected.
        gpio_pad_in[5] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            if (e == 3) gpio_pad_in[5] = 1'b0;
            step();
            check($sformatf("gl_out_e%0d", e), gpio_filt_out, 32'h0);
            check($sformatf("gl_pulse_e%0d", e), change_pulse, 32'h0);
        end
        // A 4-cycle pulse needs the full 4 ticks from a cleared count.
        for (int e = 1; e <= 10; e++) begin
            if (e == 1) gpio_pad_in[5] = 1'b1;
            if (e == 5) gpio_pad_in[5] = 1'b0;
            step();
            check($sformatf("p4_out_e%0d", e), gpio_filt_out,
                  (e >= 6 && e < 10) ? 32'h20 : 32'h0);
            check($sformatf("p4_pulse_e%0d", e), change_pulse,
                  (e == 6 || e == 10) ? 32'h20 : 32'h0);
        end

        // Prescaled tick: period 10, threshold 3.
        do_reset();
        cfg_prescale    = 16'd9;
        cfg_threshold   = 4'd3;
        gpio_pad_in[31] = 1'b1;
        for (int e = 1; e <= 31; e++) begin
            step();
            check($sformatf("ps_tick_e%0d", e), {31'b0, tick_o},
                  (e % 10 == 0) ? 32'h1 : 32'h0);
            check($sformatf("ps_out_e%0d", e), gpio_filt_out,
                  (e >= 30) ? 32'h8000_0000 : 32'h0);
            check($sformatf("ps_pulse_e%0d", e), change_pulse,
                  (e == 30) ? 32'h8000_0000 : 32'h0);
        end

        // Threshold 0 acts as 1: 3-edge latency.
        do_reset();
        cfg_prescale   = 16'd0;
        cfg_threshold  = 4'd0;
        gpio_pad_in[1] = 1'b1;
        step();
        step();
        check("thr0_out_e2", gpio_filt_out, 32'h0);
        step();
        check("thr0_out_e3", gpio_filt_out, 32'h2);
        check("thr0_pulse_e3", change_pulse, 32'h2);

        // Enable dropped mid-count (cnt=2 of 4): output follows sync next edge.
        do_reset();
        cfg_threshold  = 4'd4;
        gpio_pad_in[3] = 1'b1;
        for (int e = 1; e <= 4; e++) step();
        check("en_out_e4", gpio_filt_out, 32'h0);
        cfg_enable[3] = 1'b0;
        step();
        check("en_out_e5", gpio_filt_out, 32'h8);
        check("en_pulse_e5", change_pulse, 32'h8);
        cfg_enable[3] = 1'b1;

        // Reset mid-operation: counters at 1, prescaler at 5.
        do_reset();
        cfg_prescale  = 16'd9;
        cfg_threshold = 4'd3;
        gpio_pad_in   = 32'h0000_00F0;
        for (int e = 1; e <= 15; e++) step();
        check("mid_out_e15", gpio_filt_out, 32'h0);
        HRESET = 1'b1;
        step();
        check("mrst_out", gpio_filt_out, 32'h0);
        check("mrst_pulse", change_pulse, 32'h0);
        check("mrst_tick", {31'b0, tick_o}, 32'h0);
        HRESET = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            step();
            check($sformatf("mr_out_e%0d", e), gpio_filt_out,
                  (e >= 30) ? 32'h0000_00F0 : 32'h0);
            if (e >= 29) begin
                check($sformatf("mr_pulse_e%0d", e), change_pulse,
                      (e == 30) ? 32'h0000_00F0 : 32'h0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
